sd_init_sequencer: RTL

Card-initialization sequencer that sits directly upstream of the SD command engine. On a software start it drives the engine's command port through CMD0 → CMD8 → (CMD55 + ACMD41) loop → CMD58 → CMD16. It evaluates each 40-bit response and reports card version, capacity class, OCR and a fault code to the register block. Only the 48-bit-frame/R1/R3/R7 responses the command engine supports are used; R2 commands are out of scope.

---
 rtl/sd_init_pkg.sv | 36 +++
 rtl/sd_init_resp_eval.sv | 58 +++++
 rtl/sd_init_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sd_init_pkg.sv
// sd_init_pkg: shared types and constants for the SD card-initialization sequencer.
//   state_t   - sequencer FSM states
//   step_t    - which command of the init sequence is in progress
//   outcome_t - latched engine terminal outcome
//   ERR_*     - fault codes reported on err_code
//   IDX_*     - command indices driven to the engine
package sd_init_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_EVAL, ST_GAP, ST_DONE, ST_FAIL} state_t;
   typedef enum logic [2:0] {S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58, S_CMD16} step_t;
   typedef enum logic [1:0] {OC_DONE, OC_CRC, OC_TIMEOUT} outcome_t;
   localparam logic [3:0] ERR_NONE    = 4'd0;
   localparam logic [3:0] ERR_ECHO    = 4'd1;
   localparam logic [3:0] ERR_CRC     = 4'd2;
   localparam logic [3:0] ERR_TIMEOUT = 4'd3;
   localparam logic [3:0] ERR_RETRIES = 4'd4;
   localparam logic [3:0] ERR_STATUS  = 4'd5;
   localparam logic [3:0] ERR_VOLTAGE = 4'd6;
   localparam logic [3:0] ERR_ABORT   = 4'd7;
   localparam logic [5:0] IDX_CMD0   = 6'd0;
   localparam logic [5:0] IDX_CMD8   = 6'd8;
   localparam logic [5:0] IDX_CMD16  = 6'd16;
   localparam logic [5:0] IDX_CMD55  = 6'd55;
   localparam logic [5:0] IDX_CMD58  = 6'd58;
   localparam logic [5:0] IDX_ACMD41 = 6'd41;
   localparam logic [11:0] CMD8_PATTERN   = 12'h1AA;
   localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
   localparam logic [31:0] ACMD41_ARG_HCS = 32'h40FF_8000;
   localparam logic [31:0] ACMD41_ARG_STD = 32'h00FF_8000;
   function automatic logic [5:0] cmd_idx(step_t s);
      return s == S_CMD8   ? IDX_CMD8   :
             s == S_CMD55  ? IDX_CMD55  :
             s == S_ACMD41 ? IDX_ACMD41 :
             s == S_CMD58  ? IDX_CMD58  :
             s == S_CMD16  ? IDX_CMD16  : IDX_CMD0;
   endfunction
endpackage

// File: rtl/sd_init_resp_eval.sv
// sd_init_resp_eval: combinational judgement of one command response.
//   i_step/i_outcome/i_payload - command just completed and what the engine returned
//   i_last                     - this ACMD41 attempt is the final one allowed
//   o_next                     - step to issue next on success or retry
//   o_retry                    - ACMD41 card still busy, loop back via the gap
//   o_err                      - nonzero fault code ends the sequence
module sd_init_resp_eval
   import sd_init_pkg::*;
(
   input  step_t       i_step,
   input  outcome_t    i_outcome,
   input  logic [31:0] i_payload,
   input  logic        i_last,
   output step_t       o_next,
   output logic        o_retry,
   output logic [3:0]  o_err
);
   logic [3:0] w_r1_err;
   logic       w_unused;
   assign w_unused = ^i_payload[14:12];
   assign w_r1_err = i_outcome == OC_TIMEOUT ? ERR_TIMEOUT :
                     i_outcome == OC_CRC     ? ERR_CRC     :
                     |i_payload[31:19]       ? ERR_STATUS  : ERR_NONE;
   always_comb begin
      o_next  = i_step;
      o_retry = 1'b0;
      o_err   = ERR_NONE;
      case (i_step)
         S_CMD0: o_next = S_CMD8;
         S_CMD8: begin
            o_next = S_CMD55;
            o_err  = i_outcome == OC_CRC ? ERR_CRC :
                     (i_outcome == OC_DONE && i_payload[11:0] != CMD8_PATTERN) ? ERR_ECHO : ERR_NONE;
         end
         S_CMD55: begin
            o_next = S_ACMD41;
            o_err  = w_r1_err;
         end
         // R3 carries no valid CRC, so a crc_error still delivers a usable OCR
         S_ACMD41: begin
            if (i_outcome == OC_TIMEOUT) o_err = ERR_TIMEOUT;
            else if (i_payload[31]) o_next = S_CMD58;
            else if (i_payload[23:15] == '0) o_err = ERR_VOLTAGE;
            else if (i_last) o_err = ERR_RETRIES;
            else begin
               o_retry = 1'b1;
               o_next  = S_CMD55;
            end
         end
         S_CMD58: begin
            o_next = S_CMD16;
            o_err  = i_outcome == OC_TIMEOUT ? ERR_TIMEOUT : ERR_NONE;
         end
         S_CMD16: o_err = w_r1_err;
         default: ;
      endcase
   end
endmodule

// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer: drives the SD command engine through CMD0, CMD8, CMD55/ACMD41 loop, CMD58, CMD16.
//   PCLK_i/PRESET_i                          - clock, synchronous active-high reset
//   init_start/init_abort                    - software control
//   init_busy/init_done/init_error/err_code  - sequence status
//   card_v2/card_hc/card_ocr/retry_count     - discovered card properties
//   cmd_index/cmd_argument/cmd_start         - command request to the engine
//   cmd_done/cmd_timeout/cmd_crc_error/cmd_response - engine completion
module sd_init_sequencer
   import sd_init_pkg::*;
#(
   parameter int MAX_RETRIES = 1000,
   parameter int RETRY_GAP   = 1024,
   parameter int BLOCK_LEN   = 512
)(
   input  logic        PCLK_i,
   input  logic        PRESET_i,
   input  logic        init_start,
   input  logic        init_abort,
   output logic        init_busy,
   output logic        init_done,
   output logic        init_error,
   output logic [3:0]  err_code,
   output logic        card_v2,
   output logic        card_hc,
   output logic [31:0] card_ocr,
   output logic [15:0] retry_count,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_argument,
   output logic        cmd_start,
   input  logic        cmd_done,
   input  logic        cmd_timeout,
   input  logic        cmd_crc_error,
   input  logic [39:0] cmd_response
);
   localparam int GAP_W = RETRY_GAP > 1 ? $clog2(RETRY_GAP) : 1;
   state_t      r_state, w_state_n;
   step_t       r_step, w_step_n, w_eval_next;
   outcome_t    r_outcome, w_outcome;
   logic [31:0] r_payload, r_ocr, r_arg, w_arg_n;
   logic [15:0] r_retry, w_retry_inc;
   logic [5:0]  r_idx;
   logic [3:0]  r_err_code, w_eval_err, w_fail_code;
   logic [GAP_W-1:0] r_gap;
   logic        r_done, r_error, r_v2, r_hc, w_eval_retry, w_any, w_abort, w_unused;
   assign w_unused    = ^cmd_response[39:32];
   assign w_any       = cmd_done | cmd_timeout | cmd_crc_error;
   assign w_outcome   = cmd_timeout ? OC_TIMEOUT : cmd_crc_error ? OC_CRC : OC_DONE;
   // FAIL is left alone so an abort held high cannot keep the sequencer busy
   assign w_abort     = init_abort && r_state != ST_IDLE && r_state != ST_FAIL;
   assign w_retry_inc = &r_retry ? r_retry : r_retry + 16'd1;
   assign w_arg_n     = w_step_n == S_CMD8   ? CMD8_ARG :
                        w_step_n == S_ACMD41 ? (r_v2 ? ACMD41_ARG_HCS : ACMD41_ARG_STD) :
                        w_step_n == S_CMD16  ? 32'(BLOCK_LEN) : '0;
   sd_init_resp_eval u_eval (
      .i_step    (r_step),
      .i_outcome (r_outcome),
      .i_payload (r_payload),
      .i_last    (w_retry_inc == 16'(MAX_RETRIES)),
      .o_next    (w_eval_next),
      .o_retry   (w_eval_retry),
      .o_err     (w_eval_err)
   );
   always_comb begin
      w_state_n   = r_state;
      w_step_n    = r_step;
      w_fail_code = ERR_ABORT;
      if (w_abort) w_state_n = ST_FAIL;
      else case (r_state)
         ST_IDLE: if (init_start) begin
            w_state_n = ST_ISSUE;
            w_step_n  = S_CMD0;
         end
         ST_ISSUE: w_state_n = ST_WAIT;
         ST_WAIT:  w_state_n = w_any ? ST_EVAL : ST_WAIT;
         ST_EVAL: begin
            w_fail_code = w_eval_err;
            w_step_n    = w_eval_next;
            w_state_n   = w_eval_err != ERR_NONE ? ST_FAIL :
                          w_eval_retry           ? ST_GAP  :
                          r_step == S_CMD16      ? ST_DONE : ST_ISSUE;
         end
         ST_GAP:  w_state_n = r_gap == GAP_W'(RETRY_GAP - 1) ? ST_ISSUE : ST_GAP;
         default: w_state_n = ST_IDLE;
      endcase
   end
   always_ff @(posedge PCLK_i) begin
      if (PRESET_i) begin
         r_state    <= ST_IDLE;
         r_step     <= S_CMD0;
         r_outcome  <= OC_DONE;
         r_payload  <= '0;
         r_ocr      <= '0;
         r_arg      <= '0;
         r_idx      <= '0;
         r_retry    <= '0;
         r_err_code <= ERR_NONE;
         r_gap      <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_v2       <= 1'b0;
         r_hc       <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_step  <= w_step_n;
         r_gap   <= r_state == ST_GAP ? r_gap + 1'b1 : '0;
         if (r_state == ST_IDLE && init_start) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_v2       <= 1'b0;
            r_hc       <= 1'b0;
            r_ocr      <= '0;
            r_retry    <= '0;
         end
         // command fields are captured on entry to ISSUE and held through WAIT
         if (w_state_n == ST_ISSUE && r_state != ST_ISSUE) begin
            r_idx <= cmd_idx(w_step_n);
            r_arg <= w_arg_n;
         end
         if (r_state == ST_WAIT && w_any) begin
            r_outcome <= w_outcome;
            r_payload <= cmd_response[31:0];
         end
         if (r_state == ST_EVAL && !w_abort) begin
            if (r_step == S_CMD8) r_v2 <= r_outcome == OC_DONE && r_payload[11:0] == CMD8_PATTERN;
            if ((r_step == S_ACMD41 || r_step == S_CMD58) && r_outcome != OC_TIMEOUT) r_ocr <= r_payload;
            if (r_step == S_ACMD41 && r_outcome != OC_TIMEOUT) r_retry <= w_retry_inc;
            if (r_step == S_CMD58 && r_outcome != OC_TIMEOUT) r_hc <= r_payload[30];
         end
         if (w_state_n == ST_FAIL && r_state != ST_FAIL) r_err_code <= w_fail_code;
         if (r_state == ST_DONE) r_done <= 1'b1;
         if (r_state == ST_FAIL) r_error <= 1'b1;
      end
   end
   assign init_busy    = r_state != ST_IDLE;
   assign init_done    = r_done;
   assign init_error   = r_error;
   assign err_code     = r_err_code;
   assign card_v2      = r_v2;
   assign card_hc      = r_hc;
   assign card_ocr     = r_ocr;
   assign retry_count  = r_retry;
   assign cmd_index    = r_idx;
   assign cmd_argument = r_arg;
   assign cmd_start    = r_state == ST_ISSUE;
endmodule
